// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide unit.
// The optional early-out feature of muldiv_seq is enabled by defining MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

  // Operation select, encoded exactly as presented on the op port
  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } op_t;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Quotient returned for a zero divisor; sliced down to the datapath width
  localparam logic [63:0] DIV0_QUOT = '1;

  // True for the two operations that use the restoring divider
  function automatic logic isDivOp(input op_t o);
    return (o == OP_DIV) || (o == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the shift-add multiplier or the
// restoring divider.
//   Multiply: acc is the running product, a holds the multiplicand shifted left
//             by the number of bits consumed, b holds the multiplier bits not yet
//             consumed (LSB first).
//   Divide:   acc is {remainder, quotient}, a holds the dividend whose bit W-1
//             is the next one brought down (MSB first), b is the divisor.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           isDiv_i,
  input  logic [2*W-1:0] acc_i,
  input  logic [2*W-1:0] a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] acc_o,
  output logic [2*W-1:0] a_o,
  output logic [W-1:0]   b_o
);

  logic [W:0] partRem;
  logic [W:0] diff;

  // Compute the next accumulator/operand values for one multiplier or quotient bit
  always_comb begin
    acc_o   = acc_i;
    a_o     = {a_i[2*W-2:0], 1'b0};
    b_o     = b_i;
    partRem = '0;
    diff    = '0;
    if (isDiv_i) begin
      partRem = {acc_i[2*W-1:W], a_i[W-1]};
      diff    = partRem - {1'b0, b_i};
      if (!diff[W]) begin
        acc_o = {diff[W-1:0], acc_i[W-2:0], 1'b1};
      end else begin
        acc_o = {partRem[W-1:0], acc_i[W-2:0], 1'b0};
      end
    end else begin
      if (b_i[0]) begin
        acc_o = acc_i + a_i;
      end
      b_o = {1'b0, b_i[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned 8-bit multiply/divide unit feeding the register
// file write port. One multiplier/quotient bit is processed per RUN cycle and the
// result leaves as a single-cycle write request.
// Optional feature: define MULDIV_EARLY_OUT_EN to finish RUN early when the
// product is already final or the divisor is zero.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int W  = 8,
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [W-1:0]  opA,
  input  logic [W-1:0]  opB,
  input  logic [PW:0]   dst,
  output logic          busy,
  output logic          wr_en,
  output logic [PW:0]   wr_addr,
  output logic [W-1:0]  wr_dat,
  output logic          div0
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t         state_q, state_d;
  op_t            op_q;
  logic [CW-1:0]  count_q, count_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   dividend_q;
  logic [PW:0]    dst_q;
  logic           wrEn_q, wrEn_d;
  logic [PW:0]    wrAddr_q, wrAddr_d;
  logic [W-1:0]   wrDat_q, wrDat_d;
  logic           div0_q, div0_d;

  logic [2*W-1:0] stepAcc;
  logic [2*W-1:0] stepA;
  logic [W-1:0]   stepB;
  logic           accept;
  logic           divZero;
  logic           earlyOut;
  logic           finish;
  logic [W-1:0]   result;

  assign accept  = (state_q == S_IDLE) && start;
  assign divZero = isDivOp(op_q) && (b_q == '0);

  muldiv_step #(.W(W)) uStep (
    .isDiv_i (isDivOp(op_q)),
    .acc_i   (acc_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .acc_o   (stepAcc),
    .a_o     (stepA),
    .b_o     (stepB)
  );

`ifdef MULDIV_EARLY_OUT_EN
  // Multiply is final once no multiplier bits remain; a zero divisor needs no iterations
  assign earlyOut = isDivOp(op_q) ? divZero : (stepB == '0);
`else
  assign earlyOut = 1'b0;
`endif

  // Select the result from the accumulator after the current step, with the zero-divisor override
  always_comb begin
    result = '0;
    case (op_q)
      OP_MUL:  result = stepAcc[W-1:0];
      OP_MULH: result = stepAcc[2*W-1:W];
      OP_DIV:  result = divZero ? DIV0_QUOT[W-1:0] : stepAcc[W-1:0];
      OP_REM:  result = divZero ? dividend_q : stepAcc[2*W-1:W];
      default: result = '0;
    endcase
  end

  // Next-state logic for the sequencer, iteration registers and write port
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    wrEn_d   = 1'b0;
    wrAddr_d = wrAddr_q;
    wrDat_d  = wrDat_q;
    div0_d   = div0_q;
    finish   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          count_d = CW'(W - 1);
          acc_d   = '0;
          a_d     = {{W{1'b0}}, opA};
          b_d     = opB;
          div0_d  = 1'b0;
        end
      end
      S_RUN: begin
        acc_d   = stepAcc;
        a_d     = stepA;
        b_d     = stepB;
        count_d = count_q - CW'(1);
        finish  = (count_q == '0) || earlyOut;
        if (finish) begin
          state_d  = S_DONE;
          wrEn_d   = 1'b1;
          wrAddr_d = dst_q;
          wrDat_d  = result;
          if (divZero) begin
            div0_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, iteration and write-port registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      wrEn_q   <= 1'b0;
      wrAddr_q <= '0;
      wrDat_q  <= '0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      wrEn_q   <= wrEn_d;
      wrAddr_q <= wrAddr_d;
      wrDat_q  <= wrDat_d;
      div0_q   <= div0_d;
    end
  end

  // Capture the operation, destination and raw dividend when a request is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_MUL;
      dst_q      <= '0;
      dividend_q <= '0;
    end else if (accept) begin
      op_q       <= op_t'(op);
      dst_q      <= dst;
      dividend_q <= opA;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign wr_en   = wrEn_q;
  assign wr_addr = wrAddr_q;
  assign wr_dat  = wrDat_q;
  assign div0    = div0_q;

endmodule
